// File: rtl/smaesh_word_bridge.sv
// Bridges a 32-bit word stream to the wide shared key/plaintext/ciphertext
// handshakes of the masked AES core, in both directions.
module smaesh_word_bridge #(
    parameter int d = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             din_valid,
    output logic             din_ready,
    input  logic [31:0]      din_data,
    input  logic             din_last,
    output logic             core_in_valid,
    input  logic             core_in_ready,
    output logic [128*d-1:0] core_shares_key,
    output logic [128*d-1:0] core_shares_plaintext,
    input  logic             core_out_valid,
    output logic             core_out_ready,
    input  logic [128*d-1:0] core_shares_ciphertext,
    output logic             dout_valid,
    input  logic             dout_ready,
    output logic [31:0]      dout_data,
    output logic             dout_last,
    output logic             frame_err
);
    localparam int IN_WORDS  = 8 * d;
    localparam int KEY_WORDS = 4 * d;
    localparam int OUT_WORDS = 4 * d;
    localparam int WCW       = $clog2(IN_WORDS);
    localparam int OCW       = $clog2(OUT_WORDS);

    typedef enum logic {LOAD, PRESENT} in_state_t;
    typedef enum logic {EMPTY, SEND} out_state_t;

    in_state_t      in_state_reg, in_state_next;
    logic [WCW-1:0] wcnt_reg, wcnt_next;
    logic           frame_err_reg, frame_err_next;
    logic           at_end;
    logic           word_wr;
    logic [31:0]    in_word_reg [IN_WORDS];

    out_state_t     out_state_reg, out_state_next;
    logic [OCW-1:0] ocnt_reg, ocnt_next;
    logic           capture;
    logic [31:0]    out_word_reg [OUT_WORDS];

    // ------------------------------------------------------------------
    // Input path
    // ------------------------------------------------------------------
    assign at_end = (wcnt_reg == WCW'(IN_WORDS - 1));
    // Words of a frame that is already known to be malformed are not stored.
    assign word_wr = (in_state_reg == LOAD) && din_valid && (din_last == at_end);

    always_ff @(posedge clk) begin
        if (rst) begin
            in_state_reg  <= LOAD;
            wcnt_reg      <= '0;
            frame_err_reg <= 1'b0;
        end else begin
            in_state_reg  <= in_state_next;
            wcnt_reg      <= wcnt_next;
            frame_err_reg <= frame_err_next;
        end
    end

    always_comb begin
        in_state_next  = in_state_reg;
        wcnt_next      = wcnt_reg;
        frame_err_next = 1'b0;
        din_ready      = 1'b0;
        core_in_valid  = 1'b0;
        case (in_state_reg)
            LOAD: begin
                din_ready = 1'b1;
                if (din_valid) begin
                    if (at_end || din_last) begin
                        wcnt_next      = '0;
                        frame_err_next = (din_last != at_end);
                        if (din_last && at_end)
                            in_state_next = PRESENT;
                    end else begin
                        wcnt_next = wcnt_reg + WCW'(1);
                    end
                end
            end
            PRESENT: begin
                core_in_valid = 1'b1;
                if (core_in_ready)
                    in_state_next = LOAD;
            end
            default: in_state_next = LOAD;
        endcase
    end

    genvar gi;
    generate
        for (gi = 0; gi < IN_WORDS; gi++) begin : g_in_word
            always_ff @(posedge clk) begin
                if (rst)
                    in_word_reg[gi] <= '0;
                else if (word_wr && wcnt_reg == WCW'(gi))
                    in_word_reg[gi] <= din_data;
            end
            if (gi < KEY_WORDS) begin : g_key
                assign core_shares_key[32*gi +: 32] = in_word_reg[gi];
            end else begin : g_pt
                assign core_shares_plaintext[32*(gi-KEY_WORDS) +: 32] = in_word_reg[gi];
            end
        end
    endgenerate

    assign frame_err = frame_err_reg;

    // ------------------------------------------------------------------
    // Output path
    // ------------------------------------------------------------------
    assign capture = (out_state_reg == EMPTY) && core_out_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            out_state_reg <= EMPTY;
            ocnt_reg      <= '0;
        end else begin
            out_state_reg <= out_state_next;
            ocnt_reg      <= ocnt_next;
        end
    end

    always_comb begin
        out_state_next = out_state_reg;
        ocnt_next      = ocnt_reg;
        core_out_ready = 1'b0;
        dout_valid     = 1'b0;
        dout_last      = 1'b0;
        case (out_state_reg)
            EMPTY: begin
                core_out_ready = 1'b1;
                if (core_out_valid) begin
                    out_state_next = SEND;
                    ocnt_next      = '0;
                end
            end
            SEND: begin
                dout_valid = 1'b1;
                dout_last  = (ocnt_reg == OCW'(OUT_WORDS - 1));
                if (dout_ready) begin
                    if (dout_last) begin
                        out_state_next = EMPTY;
                        ocnt_next      = '0;
                    end else begin
                        ocnt_next = ocnt_reg + OCW'(1);
                    end
                end
            end
            default: out_state_next = EMPTY;
        endcase
    end

    generate
        for (gi = 0; gi < OUT_WORDS; gi++) begin : g_out_word
            always_ff @(posedge clk) begin
                if (rst)
                    out_word_reg[gi] <= '0;
                else if (capture)
                    out_word_reg[gi] <= core_shares_ciphertext[32*gi +: 32];
            end
        end
    endgenerate

    assign dout_data = out_word_reg[ocnt_reg];

endmodule

// File: tb/tb_smaesh_word_bridge.sv
// Directed bench for smaesh_word_bridge with d=2 (16-word input frames,
// 8-word ciphertext frames).
`timescale 1ns/1ps
module tb_smaesh_word_bridge;
    localparam int D = 2;

    logic             clk = 1'b0;
    logic             rst;
    logic             din_valid;
    logic             din_ready;
    logic [31:0]      din_data;
    logic             din_last;
    logic             core_in_valid;
    logic             core_in_ready;
    logic [128*D-1:0] core_shares_key;
    logic [128*D-1:0] core_shares_plaintext;
    logic             core_out_valid;
    logic             core_out_ready;
    logic [128*D-1:0] core_shares_ciphertext;
    logic             dout_valid;
    logic             dout_ready;
    logic [31:0]      dout_data;
    logic             dout_last;
    logic             frame_err;

    int n_checks = 0;
    int n_pass   = 0;

    smaesh_word_bridge #(.d(D)) dut (
        .clk                    (clk),
        .rst                    (rst),
        .din_valid              (din_valid),
        .din_ready              (din_ready),
        .din_data               (din_data),
        .din_last               (din_last),
        .core_in_valid          (core_in_valid),
        .core_in_ready          (core_in_ready),
        .core_shares_key        (core_shares_key),
        .core_shares_plaintext  (core_shares_plaintext),
        .core_out_valid         (core_out_valid),
        .core_out_ready         (core_out_ready),
        .core_shares_ciphertext (core_shares_ciphertext),
        .dout_valid             (dout_valid),
        .dout_ready             (dout_ready),
        .dout_data              (dout_data),
        .dout_last              (dout_last),
        .frame_err              (frame_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
            $display("ok   %s = %0h", tag, obs);
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // 8 consecutive words base, base+1, ... packed word 0 at the bottom.
    function automatic logic [255:0] mk_words(input logic [31:0] base);
        logic [255:0] r;
        r = '0;
        for (int i = 0; i < 8; i++) r[32*i +: 32] = base + 32'(i);
        return r;
    endfunction

    task automatic send_word(input logic [31:0] w, input logic last);
        int n;
        din_valid = 1'b1;
        din_data  = w;
        din_last  = last;
        n = 0;
        while (!din_ready && n < 50) begin
            tick();
            n++;
        end
        if (!din_ready) check("din_ready_wait", 256'(din_ready), 256'(1));
        tick();
        din_valid = 1'b0;
        din_last  = 1'b0;
    endtask

    // Sends n words base+i; din_last set on word index last_idx (-1: never).
    task automatic send_frame(input logic [31:0] base, input int n, input int last_idx);
        for (int i = 0; i < n; i++) send_word(base + 32'(i), (i == last_idx));
    endtask

    task automatic core_accept();
        core_in_ready = 1'b1;
        tick();
        core_in_ready = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        din_valid = 0; din_data = 0; din_last = 0;
        core_in_ready = 0; core_out_valid = 0; core_shares_ciphertext = '0;
        dout_ready = 0;
        repeat (2) tick();

        check("rst_din_ready",      256'(din_ready),      256'(1));
        check("rst_core_in_valid",  256'(core_in_valid),  256'(0));
        check("rst_core_out_ready", 256'(core_out_ready), 256'(1));
        check("rst_dout_valid",     256'(dout_valid),     256'(0));
        check("rst_frame_err",      256'(frame_err),      256'(0));
        check("rst_key",            core_shares_key,      256'(0));
        rst = 1'b0;
        tick();

        // Basic frame 0..15
        send_frame(32'h0, 16, 15);
        check("f1_core_in_valid", 256'(core_in_valid), 256'(1));
        check("f1_din_ready",     256'(din_ready),     256'(0));
        check("f1_key_lo",        256'(core_shares_key[31:0]),          256'(32'h0));
        check("f1_key_hi",        256'(core_shares_key[255:224]),       256'(32'h7));
        check("f1_pt_lo",         256'(core_shares_plaintext[31:0]),    256'(32'h8));
        check("f1_pt_hi",         256'(core_shares_plaintext[255:224]), 256'(32'hF));
        check("f1_key",           core_shares_key,       mk_words(32'h0));
        check("f1_pt",            core_shares_plaintext, mk_words(32'h8));

        // Core stalls 5 cycles
        for (int c = 0; c < 5; c++) begin
            tick();
            check($sformatf("stall%0d_valid", c), 256'(core_in_valid), 256'(1));
            check($sformatf("stall%0d_ready", c), 256'(din_ready),     256'(0));
            check($sformatf("stall%0d_key", c),   core_shares_key,       mk_words(32'h0));
            check($sformatf("stall%0d_pt", c),    core_shares_plaintext, mk_words(32'h8));
        end
        core_accept();
        check("hs_din_ready",     256'(din_ready),       256'(1));
        check("hs_core_in_valid", 256'(core_in_valid),   256'(0));
        check("hs_key_kept",      core_shares_key,       mk_words(32'h0));

        // Early din_last on word 5
        send_frame(32'h50, 5, 4);
        check("early_frame_err",  256'(frame_err),     256'(1));
        check("early_no_present", 256'(core_in_valid), 256'(0));
        check("early_din_ready",  256'(din_ready),     256'(1));
        tick();
        check("early_err_pulse",  256'(frame_err),     256'(0));
        send_frame(32'h100, 16, 15);
        check("recov_valid", 256'(core_in_valid),   256'(1));
        check("recov_err",   256'(frame_err),       256'(0));
        check("recov_key",   core_shares_key,       mk_words(32'h100));
        check("recov_pt",    core_shares_plaintext, mk_words(32'h108));
        core_accept();

        // Missing din_last on word 16
        send_frame(32'h80, 16, -1);
        check("nolast_frame_err", 256'(frame_err),     256'(1));
        check("nolast_no_valid",  256'(core_in_valid), 256'(0));
        tick();
        check("nolast_err_pulse", 256'(frame_err),     256'(0));
        check("nolast_no_valid2", 256'(core_in_valid), 256'(0));
        check("nolast_din_ready", 256'(din_ready),     256'(1));

        // Ciphertext capture and serialisation with toggling dout_ready
        core_shares_ciphertext = mk_words(32'hC0DE0000);
        core_out_valid = 1'b1;
        tick();
        core_out_valid = 1'b0;
        core_shares_ciphertext = '0;
        check("ct_dout_valid",     256'(dout_valid),     256'(1));
        check("ct_core_out_ready", 256'(core_out_ready), 256'(0));
        for (int k = 0; k < 8; k++) begin
            dout_ready = 1'b0;
            tick();
            check($sformatf("ct%0d_hold", k), 256'(dout_data), 256'(32'hC0DE0000 + 32'(k)));
            dout_ready = 1'b1;
            check($sformatf("ct%0d_data", k), 256'(dout_data),      256'(32'hC0DE0000 + 32'(k)));
            check($sformatf("ct%0d_last", k), 256'(dout_last),      256'(k == 7));
            check($sformatf("ct%0d_cor", k),  256'(core_out_ready), 256'(0));
            tick();
        end
        dout_ready = 1'b0;
        check("ct_done_valid",     256'(dout_valid),     256'(0));
        check("ct_done_out_ready", 256'(core_out_ready), 256'(1));

        // Frame completion and ciphertext capture on the same edge
        send_frame(32'h200, 15, -1);
        din_valid = 1'b1; din_data = 32'h20F; din_last = 1'b1;
        core_shares_ciphertext = mk_words(32'hA0000000);
        core_out_valid = 1'b1;
        tick();
        din_valid = 1'b0; din_last = 1'b0;
        core_out_valid = 1'b0;
        check("sim_core_in_valid", 256'(core_in_valid),   256'(1));
        check("sim_dout_valid",    256'(dout_valid),      256'(1));
        check("sim_key",           core_shares_key,       mk_words(32'h200));
        check("sim_pt",            core_shares_plaintext, mk_words(32'h208));
        core_accept();
        dout_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            check($sformatf("sim%0d_data", k), 256'(dout_data), 256'(32'hA0000000 + 32'(k)));
            tick();
        end
        dout_ready = 1'b0;
        check("sim_drained", 256'(dout_valid), 256'(0));

        // Reset mid-frame and mid-send
        core_shares_ciphertext = mk_words(32'h5A000000);
        core_out_valid = 1'b1;
        tick();
        core_out_valid = 1'b0;
        dout_ready = 1'b1;
        tick();
        dout_ready = 1'b0;
        send_frame(32'h400, 9, -1);
        rst = 1'b1;
        tick();
        check("mrst_din_ready",      256'(din_ready),      256'(1));
        check("mrst_core_in_valid",  256'(core_in_valid),  256'(0));
        check("mrst_core_out_ready", 256'(core_out_ready), 256'(1));
        check("mrst_dout_valid",     256'(dout_valid),     256'(0));
        check("mrst_dout_last",      256'(dout_last),      256'(0));
        check("mrst_frame_err",      256'(frame_err),      256'(0));
        check("mrst_key",            core_shares_key,       256'(0));
        check("mrst_pt",             core_shares_plaintext, 256'(0));
        check("mrst_dout_data",      256'(dout_data),       256'(0));
        rst = 1'b0;
        tick();
        check("mrst_no_err", 256'(frame_err), 256'(0));
        send_frame(32'h300, 16, 15);
        check("fresh_valid", 256'(core_in_valid),   256'(1));
        check("fresh_err",   256'(frame_err),       256'(0));
        check("fresh_key",   core_shares_key,       mk_words(32'h300));
        check("fresh_pt",    core_shares_plaintext, mk_words(32'h308));
        core_accept();
        check("fresh_din_ready", 256'(din_ready), 256'(1));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end
endmodule
